// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl -- built-in self-test sequencer for a single 2-input gate.
//
// A run walks the four input vectors 00,01,10,11 across the gate under test.
// Each vector is driven for one cycle, allowed to settle for SETTLE_CYCLES
// cycles, and then the gate output is checked against the expected function.
// Every output is registered.
//
// Parameters
//   SETTLE_CYCLES  wait cycles between driving a vector and sampling (0..15)
//   ERR_W          width of the saturating mismatch counter
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   start          begin a run (sampled only while idle)
//   op[1:0]        expected function: 00 AND, 01 OR, 10 XOR, 11 NAND
//   gate_a/gate_b  operands driven to the gate under test
//   gate_out       output returned by the gate under test
//   busy           high while vectors are being applied and checked
//   done           one-cycle pulse when the run completes
//   pass           run result, held until the next accepted start
//   err_cnt        mismatch count of the current or last run
//
// Optional feature (macro GATE_BIST_ERRLOG_EN)
//   first_fail_vld  set by the first mismatch of a run
//   first_fail_vec  vector index of that first mismatch
module gate_bist_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ERR_W         = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    output logic             gate_a,
    output logic             gate_b,
    input  logic             gate_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt
`ifdef GATE_BIST_ERRLOG_EN
    ,
    output logic             first_fail_vld,
    output logic [1:0]       first_fail_vec
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [ERR_W-1:0] ERR_MAX     = '1;
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       op_q, op_d;
    logic [3:0]       settle_q, settle_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             pass_q, pass_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             gate_a_q, gate_a_d;
    logic             gate_b_q, gate_b_d;
    logic             expect_out;
    logic             mismatch;
`ifdef GATE_BIST_ERRLOG_EN
    logic             ff_vld_q, ff_vld_d;
    logic [1:0]       ff_vec_q, ff_vec_d;
`endif

    // Reference function evaluated on the vector currently on the gate pins.
    always_comb begin
        expect_out = 1'b0;
        unique case (op_q)
            2'b00: expect_out = gate_a_q & gate_b_q;
            2'b01: expect_out = gate_a_q | gate_b_q;
            2'b10: expect_out = gate_a_q ^ gate_b_q;
            2'b11: expect_out = ~(gate_a_q & gate_b_q);
            default: expect_out = 1'b0;
        endcase
        mismatch = (state_q == S_CHECK) && (gate_out != expect_out);
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        op_d     = op_q;
        settle_d = settle_q;
        err_d    = err_q;
        pass_d   = pass_q;
`ifdef GATE_BIST_ERRLOG_EN
        ff_vld_d = ff_vld_q;
        ff_vec_d = ff_vec_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    idx_d   = 2'd0;
`ifdef GATE_BIST_ERRLOG_EN
                    ff_vld_d = 1'b0;
                    ff_vec_d = 2'd0;
`endif
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                settle_d = 4'd0;
                state_d  = (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 1'b1;
                    end
`ifdef GATE_BIST_ERRLOG_EN
                    if (!ff_vld_q) begin
                        ff_vld_d = 1'b1;
                        ff_vec_d = idx_q;
                    end
`endif
                end
                if (idx_q == 2'd3) begin
                    // pass must reflect the final vector's check, so use the
                    // updated count rather than the registered one.
                    pass_d  = (err_d == '0);
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_DRIVE;
                end
            end
            S_DONE: begin
                idx_d   = 2'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        busy_d   = (state_d == S_DRIVE) || (state_d == S_SETTLE) || (state_d == S_CHECK);
        done_d   = (state_d == S_DONE);
        gate_a_d = busy_d & idx_d[1];
        gate_b_d = busy_d & idx_d[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= 2'd0;
            op_q     <= 2'd0;
            settle_q <= 4'd0;
            err_q    <= '0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            gate_a_q <= 1'b0;
            gate_b_q <= 1'b0;
`ifdef GATE_BIST_ERRLOG_EN
            ff_vld_q <= 1'b0;
            ff_vec_q <= 2'd0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            op_q     <= op_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            pass_q   <= pass_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            gate_a_q <= gate_a_d;
            gate_b_q <= gate_b_d;
`ifdef GATE_BIST_ERRLOG_EN
            ff_vld_q <= ff_vld_d;
            ff_vec_q <= ff_vec_d;
`endif
        end
    end

    assign gate_a  = gate_a_q;
    assign gate_b  = gate_b_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_cnt = err_q;
`ifdef GATE_BIST_ERRLOG_EN
    assign first_fail_vld = ff_vld_q;
    assign first_fail_vec = ff_vec_q;
`endif

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Testbench for gate_bist_ctrl. The gate under test is a truth table driven
// by the bench; expected run results are queued when a start is issued and a
// monitor compares them cycle by cycle against the DUT outputs.
module tb_gate_bist_ctrl;

    localparam int S  = 2;
    localparam int EW = 2;
    localparam int L  = 4 * (S + 2);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'd0;
    logic          gate_a, gate_b, gate_out;
    logic          busy, done, pass;
    logic [EW-1:0] err_cnt;
`ifdef GATE_BIST_ERRLOG_EN
    logic          first_fail_vld;
    logic [1:0]    first_fail_vec;
`endif

    // Truth table of the gate under test, indexed by {a,b}.
    logic [3:0] tt = 4'b1000;
    assign gate_out = tt[{gate_a, gate_b}];

    gate_bist_ctrl #(
        .SETTLE_CYCLES(S),
        .ERR_W(EW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .op(op),
        .gate_a(gate_a),
        .gate_b(gate_b),
        .gate_out(gate_out),
        .busy(busy),
        .done(done),
        .pass(pass),
        .err_cnt(err_cnt)
`ifdef GATE_BIST_ERRLOG_EN
        ,
        .first_fail_vld(first_fail_vld),
        .first_fail_vec(first_fail_vec)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int   e0;
        int   err;
        bit   pass;
        bit   ffv;
        int   ffvec;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   last_pass = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit ref_fn(input int o, input int a, input int b);
        case (o)
            0: return bit'(a & b);
            1: return bit'(a | b);
            2: return bit'(a ^ b);
            default: return bit'(!(a & b));
        endcase
    endfunction

    function automatic exp_t model(input int o, input logic [3:0] t, input int e0);
        exp_t e;
        int max_err;
        max_err = (1 << EW) - 1;
        e.e0 = e0; e.err = 0; e.ffv = 1'b0; e.ffvec = 0;
        for (int v = 0; v < 4; v++) begin
            if (t[v] != ref_fn(o, v / 2, v % 2)) begin
                if (!e.ffv) begin
                    e.ffv = 1'b1;
                    e.ffvec = v;
                end
                if (e.err < max_err) e.err++;
            end
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares DUT outputs #1 after every rising edge.
    initial begin
        int j;
        forever begin
            @(posedge clk);
            #1;
            if (rst) continue;
            if (q.size() > 0 && cyc >= q[0].e0) begin
                j = cyc - q[0].e0;
                if (j < L) begin
                    chk("run_busy", busy, 1);
                    chk("run_done", done, 0);
                    chk("run_pass_clear", pass, 0);
                    chk("run_gate_a", gate_a, (j / (S + 2)) / 2);
                    chk("run_gate_b", gate_b, (j / (S + 2)) % 2);
`ifdef GATE_BIST_ERRLOG_EN
                    if (j == 0) chk("ff_vld_clear", first_fail_vld, 0);
`endif
                end else begin
                    chk("end_done", done, 1);
                    chk("end_busy", busy, 0);
                    chk("end_gate_a", gate_a, 0);
                    chk("end_gate_b", gate_b, 0);
                    chk("end_err_cnt", int'(err_cnt), q[0].err);
                    chk("end_pass", pass, q[0].pass);
`ifdef GATE_BIST_ERRLOG_EN
                    chk("end_ff_vld", first_fail_vld, q[0].ffv);
                    if (q[0].ffv) chk("end_ff_vec", first_fail_vec, q[0].ffvec);
`endif
                    last_pass = q[0].pass;
                    void'(q.pop_front());
                end
            end else begin
                chk("idle_done", done, 0);
                chk("idle_busy", busy, 0);
                chk("idle_gate_a", gate_a, 0);
                chk("idle_gate_b", gate_b, 0);
                chk("idle_pass_hold", pass, last_pass);
            end
        end
    end

    // Called at a negedge. early=1: the DUT is in its DONE cycle, so the first
    // sampling of start is ignored and it is accepted one edge later.
    // Returns at the negedge of the DONE cycle of this run.
    task automatic run(input logic [1:0] o, input logic [3:0] t, input bit early, input bit glitch);
        int e0;
        tt = t;
        op = o;
        start = 1'b1;
        e0 = early ? cyc + 2 : cyc + 1;
        q.push_back(model(int'(o), t, e0));
        if (early) @(negedge clk);
        @(negedge clk);
        for (int m = 0; m < L; m++) begin
            // m == S+3 lands in the first settle cycle of vector 1.
            start = glitch && (m == S + 3 || $urandom_range(0, 3) == 0);
            op = 2'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic reset_mid_run();
        int e0;
        tt = 4'b1000;
        op = 2'd0;
        start = 1'b1;
        e0 = cyc + 1;
        q.push_back(model(0, 4'b1000, e0));
        @(negedge clk);
        start = 1'b0;
        // Walk to the check cycle of vector 2.
        repeat (2 * (S + 2) + S + 1) @(negedge clk);
        rst = 1'b1;
        q.delete();
        last_pass = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_gate_a", gate_a, 0);
        chk("rst_gate_b", gate_b, 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
`ifdef GATE_BIST_ERRLOG_EN
        chk("rst_ff_vld", first_fail_vld, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        run(2'd0, 4'b1000, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] good_tt [4];
        logic [1:0] o;
        logic [3:0] t;
        bit         early;
        good_tt[0] = 4'b1000;
        good_tt[1] = 4'b1110;
        good_tt[2] = 4'b0110;
        good_tt[3] = 4'b0111;

        #1 rst = 1'b1;
        #2;
        chk("por_busy", busy, 0);
        chk("por_done", done, 0);
        chk("por_pass", pass, 0);
        chk("por_err_cnt", int'(err_cnt), 0);
        chk("por_gate_a", gate_a, 0);
        chk("por_gate_b", gate_b, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Start accepted on the first edge after reset release.
        run(2'd0, 4'b1000, 1'b0, 1'b0);        // AND, correct gate
        run(2'd0, 4'b1111, 1'b1, 1'b0);        // stuck-at-1, start during DONE
        @(negedge clk);
        run(2'd1, 4'b1000, 1'b0, 1'b1);        // OR expected, AND present; start glitches
        @(negedge clk);
        run(2'd0, 4'b0111, 1'b0, 1'b0);        // every vector wrong: saturation
        @(negedge clk);
        reset_mid_run();

        for (int i = 0; i < 25; i++) begin
            o = 2'($urandom);
            t = ($urandom_range(0, 1) == 0) ? good_tt[o] : 4'($urandom);
            early = ($urandom_range(0, 2) == 0);
            if (!early) repeat (1 + $urandom_range(0, 2)) @(negedge clk);
            run(o, t, early, $urandom_range(0, 1) == 1);
        end

        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gate_bist_ctrl.md
GATE_BIST_CTRL -- requirements
Module: gate_bist_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: wait cycles between driving a vector and sampling the gate output (legal 0..15).
REQ-002 SHALL have parameter ERR_W, default 3: width of the error counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: begin a self-test run; sampled only in IDLE.
REQ-006 SHALL have port op, input, 2: expected gate function (00 AND, 01 OR, 10 XOR, 11 NAND); sampled with start.
REQ-007 SHALL have port gate_a, output, 1: operand a to the gate under test.
REQ-008 SHALL have port gate_b, output, 1: operand b to the gate under test.
REQ-009 SHALL have port gate_out, input, 1: output of the gate under test.
REQ-010 SHALL have port busy, output, 1: high from DRIVE through CHECK of the last vector.
REQ-011 SHALL have port done, output, 1: one-cycle pulse at end of run.
REQ-012 SHALL have port pass, output, 1: run result; valid from done until next accepted start.
REQ-013 SHALL have port err_cnt, output, ERR_W: mismatch count of the last or current run.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, SETTLE, CHECK, DONE; all outputs registered.
REQ-015 IDLE with start=1 SHALL latch op, clear err_cnt and pass, set vector index to 0, and go to DRIVE.
REQ-016 Vectors SHALL be applied in order 0,1,2,3 with gate_a = index[1] and gate_b = index[0].
REQ-017 DRIVE SHALL last 1 cycle, then go to SETTLE; SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to CHECK; with SETTLE_CYCLES=0, DRIVE SHALL go directly to CHECK.
REQ-018 CHECK SHALL compare gate_out against the op function of (gate_a, gate_b) and increment err_cnt on mismatch.
REQ-019 CHECK SHALL go to DONE when index = 3; otherwise it SHALL increment index and go to DRIVE.
REQ-020 err_cnt SHALL saturate at 2^ERR_W-1 and never wrap.
REQ-021 done SHALL be high for exactly the single DONE cycle, 4*(SETTLE_CYCLES+2) edges after the start-sampling edge; DONE SHALL return to IDLE.
REQ-022 pass SHALL be set in DONE iff err_cnt = 0, and SHALL hold until the next accepted start.
REQ-023 start SHALL be ignored in every state except IDLE; changes to op during a run SHALL have no effect.
REQ-024 gate_a and gate_b SHALL hold the current vector from DRIVE through CHECK, and SHALL hold 0 in IDLE and DONE.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, gate_a=0, gate_b=0, busy=0, done=0, pass=0, err_cnt=0, and index=0, including mid-run.
REQ-026 After rst deasserts, the block SHALL accept start on the first rising edge.

Configuration
REQ-027 Macro GATE_BIST_ERRLOG_EN defined SHALL add output first_fail_vld (1 bit) and output first_fail_vec (2 bits), both cleared on reset and on accepted start.
REQ-028 With GATE_BIST_ERRLOG_EN defined, the first mismatch of a run SHALL capture its vector index into first_fail_vec and set first_fail_vld; later mismatches SHALL not alter either output.
REQ-029 Without GATE_BIST_ERRLOG_EN, neither port nor its logic SHALL exist; all other behaviour SHALL be identical.

Verification
REQ-030 Correct AND gate, op=00, SETTLE_CYCLES=2, start pulse -> done at edge 16, pass=1, err_cnt=0, vectors 00,01,10,11 seen.
REQ-031 gate_out stuck at 1, op=00 -> err_cnt=3, pass=0, first_fail_vec=00, first_fail_vld=1 (macro on).
REQ-032 AND gate, op=01 (OR) -> err_cnt=2, pass=0, first_fail_vec=01.
REQ-033 ERR_W=1, gate_out stuck at 1, op=00 -> err_cnt saturates at 1, pass=0.
REQ-034 start re-pulsed during SETTLE of vector 1 -> ignored, done still at edge 16, single done pulse.
REQ-035 rst asserted during CHECK of vector 2 -> all outputs 0 immediately; a fresh start completes a normal 16-edge run.
